aha_clock_switch_sequencer: RTL
===============================

# aha_clock_switch_sequencer

Control-side sequencer that drives the master-clock and design-clock select inputs of the clock controller. It accepts reconfiguration requests over a valid/ready handshake. For each request it gates the design clocks off, waits for the old clock to drain, changes the selects, waits for the new clock to settle, then re-enables the gates. It runs on an always-on control clock next to the clock controller, so software and test logic never change selects on live clocks.

## Interface
Parameters:
- GATE_WAIT, 32: cycles held with gates disabled before the selects change (≥1; covers one divide-by-32 period).
- SETTLE_CYCLES, 64: cycles held after the selects change before the gates re-enable (≥1).

Ports:
- CLK  input  1  always-on control clock.
- PORESETn  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  request valid.
- REQ_READY  output  1  sequencer can accept a request.
- REQ_MASTER_SEL  input  1  requested master clock (0 = MASTER_CLK_0, 1 = MASTER_CLK_1).
- REQ_DIV_SEL  input  3  requested divide select (0..5 = ÷1..÷32).
- MASTER_CLK_SELECT  output  1  to the clock controller master switch.
- DESIGN_CLK_SELECT  output  3  to the clock controller domain selectors.
- CLK_GATE_EN  output  1  enable for the design-domain clock gates.
- BUSY  output  1  a sequence is in progress.
- DONE  output  1  one-cycle pulse when a request completes.
- ERR  output  1  one-cycle pulse when a request is rejected.
- SWITCH_COUNT  output  8  count of completed switches (see Configuration).

## Operation
- States are IDLE, GATE_OFF, SETTLE and GATE_ON.
- REQ_READY = (state == IDLE). A request is accepted on a rising edge where REQ_VALID && REQ_READY. Request fields are sampled only at acceptance.
- Invalid request (REQ_DIV_SEL ≥ 6):
  - ERR pulses in the next cycle.
  - State stays IDLE and no outputs change.
- No-op request (fields equal current MASTER_CLK_SELECT and DESIGN_CLK_SELECT):
  - DONE pulses in the next cycle.
  - State stays IDLE, gates are untouched, SWITCH_COUNT is unchanged.
- Valid, changed request:
  - IDLE → GATE_OFF. CLK_GATE_EN = 0 and the counter loads GATE_WAIT-1.
  - GATE_OFF: the counter decrements. At 0, MASTER_CLK_SELECT and DESIGN_CLK_SELECT load the captured request, the counter loads SETTLE_CYCLES-1, and the state moves to SETTLE.
  - SETTLE: the counter decrements. At 0 → GATE_ON.
  - GATE_ON: CLK_GATE_EN = 1, DONE pulses, SWITCH_COUNT increments, and the state returns to IDLE.
- BUSY = (state != IDLE).
- Counter width is $clog2(max(GATE_WAIT, SETTLE_CYCLES)). It is unsigned and never wraps below 0.
- REQ_VALID asserted while busy is ignored: it is not queued and raises no error. The requester holds VALID until READY.
- Reset mid-sequence returns every output to its reset value immediately. The partially applied request is discarded.

## Timing
- Reset values:
  - REQ_READY = 1
  - MASTER_CLK_SELECT = 0, DESIGN_CLK_SELECT = 0 (MASTER_CLK_0, ÷1)
  - CLK_GATE_EN = 1
  - BUSY = 0, DONE = 0, ERR = 0, SWITCH_COUNT = 0
- All outputs are registered except REQ_READY and BUSY, which are decoded from the registered state.
- Changed request accepted at edge k:
  - CLK_GATE_EN low from edge k+1.
  - Selects update at edge k+GATE_WAIT+1.
  - CLK_GATE_EN high, DONE high, REQ_READY high at edge k+GATE_WAIT+SETTLE_CYCLES+1.
- A new request is accepted at the earliest one cycle after that edge, i.e. back-to-back acceptance while DONE is high.
- ERR and DONE for rejected and no-op requests go high at edge k+1. REQ_READY stays 1, so a following request can be accepted at edge k+1.
- CLK_GATE_EN is never high in a cycle where a select differs from its value one cycle earlier.

## Configuration
- Macro AHA_CLK_SEQ_SWITCH_COUNT_EN.
- Defined: SWITCH_COUNT is an 8-bit counter, reset to 0, incremented on each completed non-no-op switch, saturating at 255.
- Undefined: SWITCH_COUNT is tied to 8'd0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Post-reset state: release PORESETn → MASTER_CLK_SELECT=0, DESIGN_CLK_SELECT=0, CLK_GATE_EN=1, REQ_READY=1, BUSY=0.
- Default-parameter switch: request (1, 3) accepted at edge k → gate low at k+1, selects 1/3 at k+33, gate high and DONE at k+97, SWITCH_COUNT=1 (macro defined) or 0 (undefined).
- Invalid request: request with REQ_DIV_SEL=6 → ERR pulse at k+1, selects and gate unchanged, REQ_READY stays 1.
- No-op request: request equal to current (0, 0) → DONE at k+1, CLK_GATE_EN held at 1 throughout, SWITCH_COUNT unchanged.
- Reset mid-sequence: assert PORESETn low during SETTLE → all outputs return to reset values asynchronously; after release, a new request (0, 5) completes normally.
- Busy and saturation: hold REQ_VALID through a sequence with GATE_WAIT=1, SETTLE_CYCLES=1 → exactly one acceptance per sequence, READY/DONE back-to-back. After 300 alternating switches, SWITCH_COUNT=255.

Source files
------------

// File: rtl/aha_clock_switch_sequencer.sv
// aha_clock_switch_sequencer: sequences master/design clock select changes
// for the clock controller. For each request it gates the design clocks off,
// waits GATE_WAIT cycles, changes the selects, waits SETTLE_CYCLES cycles,
// then re-enables the gates.
// Optional feature macro: AHA_CLK_SEQ_SWITCH_COUNT_EN (saturating SWITCH_COUNT).
module aha_clock_switch_sequencer #(
    parameter int unsigned GATE_WAIT     = 32,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       PORESETn,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_MASTER_SEL,
    input  logic [2:0] REQ_DIV_SEL,
    output logic       MASTER_CLK_SELECT,
    output logic [2:0] DESIGN_CLK_SELECT,
    output logic       CLK_GATE_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] SWITCH_COUNT
);

    localparam int unsigned MAX_WAIT = (GATE_WAIT > SETTLE_CYCLES) ? GATE_WAIT : SETTLE_CYCLES;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int unsigned DIV_W    = 3;
    localparam logic [DIV_W-1:0] DIV_LIMIT = DIV_W'(6);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SETTLE   = 2'd2,
        GATE_ON  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               master_q, master_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               cap_master_q, cap_master_d;
    logic [DIV_W-1:0]   cap_div_q, cap_div_d;
    logic               gate_q, gate_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic accept_c;
    logic req_invalid_c;
    logic req_noop_c;
    logic cnt_zero_c;

    assign REQ_READY     = (state_q == IDLE);
    assign BUSY          = (state_q != IDLE);
    assign accept_c      = REQ_VALID && REQ_READY;
    assign req_invalid_c = (REQ_DIV_SEL >= DIV_LIMIT);
    assign req_noop_c    = (REQ_MASTER_SEL == master_q) && (REQ_DIV_SEL == div_q);
    assign cnt_zero_c    = (cnt_q == '0);

    // State register
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. The gate-on step is taken on the SETTLE exit edge so
    // READY returns in the same cycle as DONE; GATE_ON only falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c && !req_invalid_c && !req_noop_c) begin
                    state_d = GATE_OFF;
                end
            end
            GATE_OFF: begin
                if (cnt_zero_c) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_zero_c) begin
                    state_d = IDLE;
                end
            end
            GATE_ON: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, counter and captured request
    always_comb begin
        cnt_d        = cnt_q;
        master_d     = master_q;
        div_d        = div_q;
        cap_master_d = cap_master_q;
        cap_div_d    = cap_div_q;
        gate_d       = gate_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (req_invalid_c) begin
                        err_d = 1'b1;
                    end else if (req_noop_c) begin
                        done_d = 1'b1;
                    end else begin
                        cap_master_d = REQ_MASTER_SEL;
                        cap_div_d    = REQ_DIV_SEL;
                        gate_d       = 1'b0;
                        cnt_d        = CNT_W'(GATE_WAIT - 1);
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_zero_c) begin
                    master_d = cap_master_q;
                    div_d    = cap_div_q;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_zero_c) begin
                    gate_d = 1'b1;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GATE_ON: begin
                gate_d = 1'b1;
            end
            default: begin
                gate_d = 1'b1;
            end
        endcase
    end

    // Output, counter and request-capture registers
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            cnt_q        <= '0;
            master_q     <= 1'b0;
            div_q        <= '0;
            cap_master_q <= 1'b0;
            cap_div_q    <= '0;
            gate_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            master_q     <= master_d;
            div_q        <= div_d;
            cap_master_q <= cap_master_d;
            cap_div_q    <= cap_div_d;
            gate_q       <= gate_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign MASTER_CLK_SELECT = master_q;
    assign DESIGN_CLK_SELECT = div_q;
    assign CLK_GATE_EN       = gate_q;
    assign DONE              = done_q;
    assign ERR               = err_q;

`ifdef AHA_CLK_SEQ_SWITCH_COUNT_EN
    logic [7:0] switch_count_q;
    logic       count_inc_c;

    assign count_inc_c = (state_q == SETTLE) && cnt_zero_c;

    // Saturating count of completed (non-no-op) switches
    always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
            switch_count_q <= 8'd0;
        end else if (count_inc_c && (switch_count_q != 8'hFF)) begin
            switch_count_q <= switch_count_q + 8'd1;
        end
    end

    assign SWITCH_COUNT = switch_count_q;
`else
    assign SWITCH_COUNT = 8'd0;
`endif

endmodule
